// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester-side and main-memory-side signals of mem_arbiter
interface mem_arbiter_if #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int ADDR_LEN = 10
);
  localparam int LINE_W = 32 << LINE_ADDR_LEN;
  logic p0_rd_req, p0_wr_req, p1_rd_req, p1_wr_req;
  logic [ADDR_LEN-1:0] p0_addr, p1_addr, mem_addr;
  logic [LINE_W-1:0] p0_wr_line, p1_wr_line, p0_rd_line, p1_rd_line;
  logic [LINE_W-1:0] mem_wr_line, mem_rd_line;
  logic p0_gnt, p1_gnt, mem_rd_req, mem_wr_req, mem_gnt, busy;
  modport slave (
    input p0_rd_req, p0_wr_req, p0_addr, p0_wr_line,
    input p1_rd_req, p1_wr_req, p1_addr, p1_wr_line,
    input mem_rd_line, mem_gnt,
    output p0_gnt, p0_rd_line, p1_gnt, p1_rd_line,
    output mem_rd_req, mem_wr_req, mem_addr, mem_wr_line, busy
  );
  modport master (
    output p0_rd_req, p0_wr_req, p0_addr, p0_wr_line,
    output p1_rd_req, p1_wr_req, p1_addr, p1_wr_line,
    output mem_rd_line, mem_gnt,
    input p0_gnt, p0_rd_line, p1_gnt, p1_rd_line,
    input mem_rd_req, mem_wr_req, mem_addr, mem_wr_line, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port line arbiter for one slow main memory; MEM_ARBITER_FIXED_PRIO_EN gives p1 fixed priority instead of round-robin
module mem_arbiter #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int ADDR_LEN = 10
) (
  input logic clk,
  input logic rst,
  mem_arbiter_if.slave bus
);
  localparam int LINE_W = 32 << LINE_ADDR_LEN;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nxt;
  logic req0, req1, sel, sel_wr, start, done, act;
  logic owner, op_wr;
  logic [ADDR_LEN-1:0] addr_q;
  logic [LINE_W-1:0] line_q, rd0_q, rd1_q;
  assign req0 = bus.p0_rd_req | bus.p0_wr_req;
  assign req1 = bus.p1_rd_req | bus.p1_wr_req;
  assign act = state == BUSY;
  assign start = state == IDLE && (req0 || req1);
  assign done = act && bus.mem_gnt;
  assign sel_wr = sel ? bus.p1_wr_req : bus.p0_wr_req;
`ifdef MEM_ARBITER_FIXED_PRIO_EN
  assign sel = req1;
`else
  logic last_owner;
  assign sel = req0 && req1 ? ~last_owner : req1;
  // remember who started the latest transfer so contention alternates
  always_ff @(posedge clk or posedge rst)
    if (rst) last_owner <= 1'b1;
    else if (start) last_owner <= sel;
`endif
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  // next state: any request starts a transfer, mem_gnt ends it
  always_comb begin
    state_nxt = state == IDLE ? (req0 || req1 ? BUSY : IDLE) : (bus.mem_gnt ? IDLE : BUSY);
  end
  // capture the winning request; writes win over reads on the same port
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      owner <= 1'b0;
      op_wr <= 1'b0;
      addr_q <= '0;
      line_q <= '0;
    end else if (start) begin
      owner <= sel;
      op_wr <= sel_wr;
      addr_q <= sel ? bus.p1_addr : bus.p0_addr;
      line_q <= sel_wr ? (sel ? bus.p1_wr_line : bus.p0_wr_line) : '0;
    end
  // read completions land in the owner's line register only
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd0_q <= '0;
      rd1_q <= '0;
    end else if (done && !op_wr) begin
      if (owner) rd1_q <= bus.mem_rd_line;
      else rd0_q <= bus.mem_rd_line;
    end
  // outputs: memory side only from registered values and only while busy
  always_comb begin
    bus.busy = act;
    bus.mem_rd_req = act && !op_wr;
    bus.mem_wr_req = act && op_wr;
    bus.mem_addr = act ? addr_q : '0;
    bus.mem_wr_line = act ? line_q : '0;
    bus.p0_gnt = done && !owner;
    bus.p1_gnt = done && owner;
    bus.p0_rd_line = rd0_q;
    bus.p1_rd_line = rd1_q;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven scoreboard bench for mem_arbiter
module tb_mem_arbiter;
  localparam int LAL = 3;
  localparam int AL = 10;
  localparam int LW = 32 << LAL;
  localparam int WORDS = 1 << LAL;
  typedef struct {
    logic own;
    logic wr;
    logic [AL-1:0] addr;
    logic [LW-1:0] wline;
    logic [LW-1:0] rline;
  } xfer_t;
  typedef struct {
    logic [1:0] rd;
    logic [1:0] wr;
    logic [AL-1:0] a0;
    logic [AL-1:0] a1;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] mw;
    int n0;
    int n1;
    logic first;
    int lat;
    logic chg;
  } vec_t;
  logic clk = 1'b0;
  logic rst;
  xfer_t sb[$];
  vec_t vt[7];
  int n_cmp = 0;
  int n_bad = 0;
  int rem[2];
  logic [LW-1:0] exp_rd[2];
  always #5 clk = ~clk;
  mem_arbiter_if #(.LINE_ADDR_LEN(LAL), .ADDR_LEN(AL)) bus ();
  mem_arbiter #(.LINE_ADDR_LEN(LAL), .ADDR_LEN(AL)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_xfer(output xfer_t x);
    int k = 0;
    while (bus.busy !== 1'b1 && k < 300) begin
      tick();
      k++;
    end
    chk("latency", k, 1);
    chk("sb_nonempty", sb.size() > 0, 1);
    x = '{default: '0};
    if (sb.size() > 0) x = sb.pop_front();
    chk("mem_rd_req", bus.mem_rd_req, !x.wr);
    chk("mem_wr_req", bus.mem_wr_req, x.wr);
    chk("mem_addr", bus.mem_addr, x.addr);
    if (x.wr) chk("mem_wr_line", bus.mem_wr_line, x.wline);
  endtask

  task automatic finish_xfer(input xfer_t x, input int lat, input logic chg);
    for (int i = 0; i < lat; i++) begin
      if (chg && i == 0) begin
        bus.p0_addr = bus.p0_addr ^ 10'h3;
        bus.p1_addr = bus.p1_addr ^ 10'h3;
      end
      tick();
      chk("hold_addr", bus.mem_addr, x.addr);
      chk("gnt_early", {bus.p1_gnt, bus.p0_gnt}, 2'b00);
    end
    bus.mem_gnt = 1'b1;
    bus.mem_rd_line = x.rline;
    #1;
    chk("gnt_pulse", {bus.p1_gnt, bus.p0_gnt}, x.own ? 2'b10 : 2'b01);
    tick();
    bus.mem_gnt = 1'b0;
    bus.mem_rd_line = '0;
    if (!x.wr) exp_rd[x.own] = x.rline;
    chk("idle_gap", {bus.busy, bus.mem_rd_req, bus.mem_wr_req}, 3'b000);
    chk("gnt_once", {bus.p1_gnt, bus.p0_gnt}, 2'b00);
    chk("p0_rd_line", bus.p0_rd_line, exp_rd[0]);
    chk("p1_rd_line", bus.p1_rd_line, exp_rd[1]);
    rem[x.own] -= 1;
    if (rem[x.own] == 0) begin
      if (x.own) begin
        bus.p1_rd_req = 1'b0;
        bus.p1_wr_req = 1'b0;
      end else begin
        bus.p0_rd_req = 1'b0;
        bus.p0_wr_req = 1'b0;
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    xfer_t x;
    logic o;
    int r[2];
    logic [LW-1:0] wl[2];
    logic [AL-1:0] a[2];
    wl[0] = {WORDS{v.w0}};
    wl[1] = {WORDS{v.w1}};
    a[0] = v.a0;
    a[1] = v.a1;
    r[0] = v.n0;
    r[1] = v.n1;
    rem[0] = v.n0;
    rem[1] = v.n1;
`ifdef MEM_ARBITER_FIXED_PRIO_EN
    o = v.n1 > 0;
`else
    o = v.first;
`endif
    for (int k = 0; k < v.n0 + v.n1; k++) begin
      if (r[o] == 0) o = ~o;
      x.own = o;
      x.wr = v.wr[o];
      x.addr = a[o];
      x.wline = wl[o];
      x.rline = {WORDS{v.mw + 32'(k)}};
      sb.push_back(x);
      r[o] -= 1;
`ifndef MEM_ARBITER_FIXED_PRIO_EN
      o = ~o;
`endif
    end
    bus.p0_rd_req = v.rd[0];
    bus.p0_wr_req = v.wr[0];
    bus.p0_addr = v.a0;
    bus.p0_wr_line = wl[0];
    bus.p1_rd_req = v.rd[1];
    bus.p1_wr_req = v.wr[1];
    bus.p1_addr = v.a1;
    bus.p1_wr_line = wl[1];
    for (int k = 0; k < v.n0 + v.n1; k++) begin
      start_xfer(x);
      finish_xfer(x, v.lat, v.chg);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: no finish within time limit");
    $fatal(1);
  end

  initial begin
    xfer_t x;
    //        rd     wr     a0      a1      w0            w1            mw            n0 n1 first lat chg
    vt[0] = '{2'b11, 2'b00, 10'h011, 10'h022, 32'h0, 32'h0, 32'h11110000, 1, 1, 1'b0, 3, 1'b0};
    vt[1] = '{2'b11, 2'b00, 10'h0C0, 10'h0D0, 32'h0, 32'h0, 32'h22220000, 2, 2, 1'b0, 2, 1'b0};
    vt[2] = '{2'b01, 2'b00, 10'h05A, 10'h000, 32'h0, 32'h0, 32'hDEADBEEF, 1, 0, 1'b0, 50, 1'b0};
    vt[3] = '{2'b00, 2'b10, 10'h000, 10'h3FF, 32'h0, 32'hA5A5A5A5, 32'h12345678, 0, 1, 1'b1, 4, 1'b0};
    vt[4] = '{2'b10, 2'b10, 10'h000, 10'h100, 32'h0, 32'h0F0F0F0F, 32'h55555555, 0, 1, 1'b1, 2, 1'b0};
    vt[5] = '{2'b10, 2'b00, 10'h000, 10'h2AB, 32'h0, 32'h0, 32'hCAFEF00D, 0, 1, 1'b1, 0, 1'b0};
    vt[6] = '{2'b01, 2'b00, 10'h001, 10'h000, 32'h0, 32'h0, 32'h600DF00D, 1, 0, 1'b0, 6, 1'b1};
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    rst = 1'b1;
    bus.p0_rd_req = 1'b1;
    bus.p0_wr_req = 1'b0;
    bus.p0_addr = 10'h155;
    bus.p0_wr_line = '0;
    bus.p1_rd_req = 1'b0;
    bus.p1_wr_req = 1'b1;
    bus.p1_addr = 10'h0AA;
    bus.p1_wr_line = '1;
    bus.mem_gnt = 1'b1;
    bus.mem_rd_line = '1;
    tick();
    tick();
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_mem_req", {bus.mem_rd_req, bus.mem_wr_req}, 2'b00);
    chk("rst_mem_addr", bus.mem_addr, '0);
    chk("rst_mem_wr_line", bus.mem_wr_line, '0);
    chk("rst_gnt", {bus.p1_gnt, bus.p0_gnt}, 2'b00);
    chk("rst_p0_rd_line", bus.p0_rd_line, '0);
    chk("rst_p1_rd_line", bus.p1_rd_line, '0);
    bus.p0_rd_req = 1'b0;
    bus.p1_wr_req = 1'b0;
    bus.mem_gnt = 1'b0;
    bus.mem_rd_line = '0;
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 7; i++) run_vec(vt[i]);
    bus.p0_rd_req = 1'b1;
    bus.p0_addr = 10'h0AA;
    x = '{own: 1'b0, wr: 1'b0, addr: 10'h0AA, wline: '0, rline: '0};
    sb.push_back(x);
    start_xfer(x);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_mem_req", {bus.mem_rd_req, bus.mem_wr_req}, 2'b00);
    chk("abort_mem_addr", bus.mem_addr, '0);
    chk("abort_p0_rd_line", bus.p0_rd_line, '0);
    chk("abort_p1_rd_line", bus.p1_rd_line, '0);
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    bus.p0_rd_req = 1'b0;
    tick();
    rst = 1'b0;
    bus.mem_gnt = 1'b1;
    bus.mem_rd_line = '1;
    #1;
    chk("late_gnt_ignored", {bus.p1_gnt, bus.p0_gnt}, 2'b00);
    tick();
    chk("late_gnt_idle", bus.busy, 1'b0);
    chk("late_gnt_rd_line", bus.p0_rd_line, '0);
    bus.mem_gnt = 1'b0;
    bus.mem_rd_line = '0;
    tick();
    run_vec(vt[0]);
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter LINE_ADDR_LEN, default 3, meaning a line holds 2^LINE_ADDR_LEN 32-bit words (LINE_W = 32*2^LINE_ADDR_LEN bits).
REQ-002 SHALL have parameter ADDR_LEN, default 10, meaning the main-memory line-address width.
REQ-003 SHALL have port clk, input, 1, the clock.
REQ-004 SHALL have port rst, input, 1, reset (asynchronous, active-high).
REQ-005 SHALL have ports pN_rd_req and pN_wr_req (N=0,1), input, 1 each, the requester N line read and line write requests.
REQ-006 SHALL have port pN_addr, input, ADDR_LEN, the requester N line address.
REQ-007 SHALL have port pN_wr_line, input, LINE_W, the requester N write line.
REQ-008 SHALL have port pN_gnt, output, 1, the requester N completion pulse.
REQ-009 SHALL have port pN_rd_line, output, LINE_W, the registered requester N read line.
REQ-010 SHALL have ports mem_rd_req and mem_wr_req, output, 1 each, the main-memory requests.
REQ-011 SHALL have port mem_addr, output, ADDR_LEN, the main-memory line address.
REQ-012 SHALL have port mem_wr_line, output, LINE_W, the main-memory write line.
REQ-013 SHALL have port mem_rd_line, input, LINE_W, the main-memory read line.
REQ-014 SHALL have port mem_gnt, input, 1, the main-memory completion handshake.
REQ-015 SHALL have port busy, output, 1, high while a transfer is owned.

Function
REQ-016 SHALL share one slow main memory between two cache controllers (I-side p0, D-side p1); at most one transfer SHALL be outstanding.
REQ-017 SHALL implement a two-state FSM:
- IDLE -> BUSY on any request.
- BUSY -> IDLE in the cycle mem_gnt=1.
REQ-018 In IDLE with a request present, SHALL select the owner and register owner, op, address and write line at the clock edge.
REQ-019 In BUSY, SHALL drive mem_rd_req or mem_wr_req, mem_addr and mem_wr_line only from the registered values.
REQ-020 SHALL ignore requester input changes during BUSY; transfers are non-abortable.
REQ-021 SHALL hold mem_rd_req, mem_wr_req, mem_addr and mem_wr_line at 0 in IDLE.
REQ-022 SHALL drive pN_gnt = mem_gnt AND BUSY AND owner==N, combinationally, for exactly one cycle.
REQ-023 SHALL never assert p0_gnt and p1_gnt together.
REQ-024 On a read completion, SHALL latch mem_rd_line into the owner's pN_rd_line at that edge; the value SHALL be valid from the next cycle and held until the owner's next read completes.
REQ-025 SHALL leave pN_rd_line unchanged on a write completion.
REQ-026 SHALL serve the write first when a port asserts rd_req and wr_req together.
REQ-027 With both ports requesting in IDLE, SHALL grant the port not served most recently (round-robin, last_owner register, reset value 1 so p0 wins first).
REQ-028 With a single requester, SHALL grant it regardless of last_owner.
REQ-029 SHALL give request-to-memory latency of 1 cycle: a request sampled at edge N gives mem request high after edge N.
REQ-030 SHALL always pass through at least one IDLE cycle between transfers, which drops the memory requests for one cycle.
REQ-031 SHALL drive busy = (state==BUSY).

Reset
REQ-032 On rst, SHALL clear immediately: state IDLE, last_owner=1, registered address/op/line=0, pN_rd_line=0.
REQ-033 While rst is high, all outputs SHALL be 0.
REQ-034 Reset during BUSY SHALL abandon the transfer and give no pN_gnt pulse; a mem_gnt arriving later in IDLE SHALL be ignored.

Configuration
REQ-035 With macro MEM_ARBITER_FIXED_PRIO_EN defined, SHALL always give p1 (D-side) priority on contention, with last_owner unused.
REQ-036 Without MEM_ARBITER_FIXED_PRIO_EN, SHALL use the round-robin of REQ-027.

Verification
REQ-037 Single read: p0_rd_req=1, p0_addr=0x05A; memory gnt after 50 cycles with line word0=0xDEADBEEF -> mem_rd_req=1, mem_addr=0x05A; one-cycle p0_gnt; p0_rd_line word0=0xDEADBEEF next cycle; p1_gnt stays 0.
REQ-038 Contention: p0 and p1 both read in the same cycle after reset -> p0 served first, then 1 IDLE cycle, then p1; with the macro defined, p1 first.
REQ-039 Back-to-back fairness: both ports hold requests for 4 transfers -> grant order p0, p1, p0, p1.
REQ-040 Write: p1_wr_req=1, p1_addr=0x3FF, wr_line all 0xA5A5A5A5 -> mem_wr_req=1, mem_wr_line matches; p1_rd_line unchanged after p1_gnt.
REQ-041 Input change mid-transfer: p0_addr changed 0x001->0x002 during BUSY -> mem_addr stays 0x001 until gnt.
REQ-042 Reset mid-transfer: rst pulse during BUSY -> mem requests 0 immediately; a later mem_gnt gives no pN_gnt; the next request starts normally.
